// File: rtl/axi4_config_master.sv
// ============================================================================
// Module      : axi4_config_master
// Description : Single-outstanding, single-beat AXI4 master for configuration
//               register access. A simple valid/ready command port is turned
//               into one AXI write (AW+W, then B) or one AXI read (AR, then R).
//               The result comes back on a valid/ready response port.
// Options     : CFG_WR_VERIFY_EN - when defined, every write that completes
//               with an OKAY response is followed by a read of the same
//               address. The read data is compared against the written data
//               and any difference is reported as an error.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi4_config_master #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 8,
    parameter int MST_ID_W     = 5,
    parameter int TRANS_RESP_W = 2,
    parameter int MST_ID       = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,

    // Command port
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_wr_i,
    input  logic [ADDR_W-1:0]       cmd_addr_i,
    input  logic [DATA_W-1:0]       cmd_wdata_i,

    // Response port
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_W-1:0]       rsp_rdata_o,
    output logic [TRANS_RESP_W-1:0] rsp_resp_o,
    output logic                    rsp_err_o,

    // AXI write address channel
    output logic [MST_ID_W-1:0]     m_awid_o,
    output logic [ADDR_W-1:0]       m_awaddr_o,
    output logic                    m_awvalid_o,
    input  logic                    m_awready_i,

    // AXI write data channel
    output logic [DATA_W-1:0]       m_wdata_o,
    output logic                    m_wvalid_o,
    input  logic                    m_wready_i,

    // AXI write response channel
    input  logic [MST_ID_W-1:0]     m_bid_i,
    input  logic [TRANS_RESP_W-1:0] m_bresp_i,
    input  logic                    m_bvalid_i,
    output logic                    m_bready_o,

    // AXI read address channel
    output logic [MST_ID_W-1:0]     m_arid_o,
    output logic [ADDR_W-1:0]       m_araddr_o,
    output logic                    m_arvalid_o,
    input  logic                    m_arready_i,

    // AXI read data channel
    input  logic [MST_ID_W-1:0]     m_rid_i,
    input  logic [DATA_W-1:0]       m_rdata_i,
    input  logic [TRANS_RESP_W-1:0] m_rresp_i,
    input  logic                    m_rvalid_i,
    output logic                    m_rready_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [MST_ID_W-1:0]     c_mst_id      = MST_ID_W'(MST_ID);
    localparam logic [TRANS_RESP_W-1:0] c_resp_okay   = '0;
    localparam logic [TRANS_RESP_W-1:0] c_resp_slverr = TRANS_RESP_W'(2);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_REQ = 3'd1,
        WR_RSP = 3'd2,
        RD_REQ = 3'd3,
        RD_RSP = 3'd4,
        RESP   = 3'd5
    } state_t;

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    state_t                  state_q;

    // Command captured at the handshake; the AXI payloads are driven straight
    // from these so they cannot move while a valid is waiting for ready.
    logic [ADDR_W-1:0]       addr_q;
    logic [DATA_W-1:0]       wdata_q;
    logic                    wr_q;

    logic                    cmd_ready_q;
    logic                    awvalid_q;
    logic                    wvalid_q;
    logic                    bready_q;
    logic                    arvalid_q;
    logic                    rready_q;

    logic                    rsp_valid_q;
    logic [DATA_W-1:0]       rsp_rdata_q;
    logic [TRANS_RESP_W-1:0] rsp_resp_q;
    logic                    rsp_err_q;

    // ------------------------------------------------------------------------
    // Handshake and error decode
    // ------------------------------------------------------------------------
    logic w_cmd_hs;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_aw_done;
    logic w_w_done;
    logic w_b_hs;
    logic w_ar_hs;
    logic w_r_hs;
    logic w_rsp_hs;
    logic w_bid_bad;
    logic w_rid_bad;
    logic w_b_err;
    logic w_rd_verify_bad;

    assign w_cmd_hs  = cmd_valid_i & cmd_ready_q;
    assign w_aw_hs   = awvalid_q & m_awready_i;
    assign w_w_hs    = wvalid_q  & m_wready_i;
    // A channel counts as done once its valid has dropped or it is being
    // accepted this cycle; AW and W may complete in either order.
    assign w_aw_done = ~awvalid_q | m_awready_i;
    assign w_w_done  = ~wvalid_q  | m_wready_i;
    assign w_b_hs    = bready_q  & m_bvalid_i;
    assign w_ar_hs   = arvalid_q & m_arready_i;
    assign w_r_hs    = rready_q  & m_rvalid_i;
    assign w_rsp_hs  = rsp_valid_q & rsp_ready_i;

    assign w_bid_bad = (m_bid_i != c_mst_id);
    assign w_rid_bad = (m_rid_i != c_mst_id);
    assign w_b_err   = w_bid_bad | (m_bresp_i != c_resp_okay);

    // A read issued on behalf of a write command is a read-back check: the
    // returned data must equal what was written and the slave must say OKAY.
    // Plain read commands leave wr_q low, so this never fires for them.
    assign w_rd_verify_bad = wr_q & ((m_rdata_i != wdata_q) | (m_rresp_i != c_resp_okay));

    // ------------------------------------------------------------------------
    // Transaction sequencer with registered AXI and response outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            cmd_ready_q <= 1'b1;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_cmd_hs) begin
                        cmd_ready_q <= 1'b0;
                        addr_q      <= cmd_addr_i;
                        wdata_q     <= cmd_wdata_i;
                        wr_q        <= cmd_wr_i;
                        // Previous result is discarded; a write reports
                        // zero read data unless a read-back overwrites it.
                        rsp_rdata_q <= '0;
                        rsp_resp_q  <= '0;
                        rsp_err_q   <= 1'b0;
                        if (cmd_wr_i) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= WR_REQ;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= RD_REQ;
                        end
                    end
                end

                WR_REQ: begin
                    if (w_aw_hs) begin
                        awvalid_q <= 1'b0;
                    end
                    if (w_w_hs) begin
                        wvalid_q <= 1'b0;
                    end
                    if (w_aw_done && w_w_done) begin
                        bready_q <= 1'b1;
                        state_q  <= WR_RSP;
                    end
                end

                WR_RSP: begin
                    if (w_b_hs) begin
                        bready_q   <= 1'b0;
                        // An unexpected BID is reported as a slave error
                        // regardless of what BRESP carried.
                        rsp_resp_q <= w_bid_bad ? c_resp_slverr : m_bresp_i;
                        rsp_err_q  <= w_b_err;
`ifdef CFG_WR_VERIFY_EN
                        // Only a clean write is worth reading back; a failed
                        // write is reported as-is.
                        if (!w_b_err) begin
                            arvalid_q <= 1'b1;
                            state_q   <= RD_REQ;
                        end else begin
                            rsp_valid_q <= 1'b1;
                            state_q     <= RESP;
                        end
`else
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
`endif
                    end
                end

                RD_REQ: begin
                    if (w_ar_hs) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= RD_RSP;
                    end
                end

                RD_RSP: begin
                    if (w_r_hs) begin
                        rready_q    <= 1'b0;
                        rsp_rdata_q <= m_rdata_i;
                        if (w_rid_bad || w_rd_verify_bad) begin
                            rsp_resp_q <= c_resp_slverr;
                            rsp_err_q  <= 1'b1;
                        end else begin
                            rsp_resp_q <= m_rresp_i;
                            rsp_err_q  <= (m_rresp_i != c_resp_okay);
                        end
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end

                RESP: begin
                    // Going through IDLE with cmd_ready high guarantees at
                    // least one idle cycle between commands.
                    if (w_rsp_hs) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end

                default: begin
                    awvalid_q   <= 1'b0;
                    wvalid_q    <= 1'b0;
                    bready_q    <= 1'b0;
                    arvalid_q   <= 1'b0;
                    rready_q    <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------------
    assign cmd_ready_o = cmd_ready_q;

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_resp_o  = rsp_resp_q;
    assign rsp_err_o   = rsp_err_q;

    assign m_awid_o    = c_mst_id;
    assign m_awaddr_o  = addr_q;
    assign m_awvalid_o = awvalid_q;

    assign m_wdata_o   = wdata_q;
    assign m_wvalid_o  = wvalid_q;

    assign m_bready_o  = bready_q;

    assign m_arid_o    = c_mst_id;
    assign m_araddr_o  = addr_q;
    assign m_arvalid_o = arvalid_q;

    assign m_rready_o  = rready_q;

endmodule

`default_nettype wire
